mem_write_buffer: RTL and testbench
===================================

# mem_write_buffer

Posted-store FIFO placed between `memory_cache` and the main memory write port. It accepts word stores from the cache in one cycle and drains them to memory in the background whenever the memory port is granted. Pending stores are tracked by word address so that later loads are either forwarded from the buffer or stalled. The `empty` output gates `halted`, so all stores reach memory before the core stops.

## Interface
- `XLEN`, 32, address width.
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `WRITE_CYCLES`, 1, cycles `mem_write_en` is held per store; ≥1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_b`  in  1  reset; asynchronous, active-low.
- `wr_valid`  in  1  cache offers a store.
- `wr_ready`  out  1  buffer can accept the offered store.
- `wr_addr`  in  XLEN  store address; bits [1:0] ignored.
- `wr_data`  in  [7:0]×[0:3]  store data; [0] is the LS byte.
- `mem_grant`  in  1  memory port free for the buffer this cycle.
- `mem_busy`  out  1  buffer owns the memory port.
- `mem_addr`  out  XLEN  write address to memory.
- `mem_data_in`  out  [7:0]×[0:3]  write data to memory.
- `mem_write_en`  out  1  memory write strobe.
- `rd_addr`  in  XLEN  load address probed by the cache.
- `fwd_hit`  out  1  a pending store matches `rd_addr`.
- `fwd_data`  out  [7:0]×[0:3]  data of the youngest matching store.
- `rd_stall`  out  1  load must wait.
- `empty`  out  1  no pending stores.

## Operation
- **Storage.** Circular FIFO with head/tail pointers that wrap modulo `DEPTH`. The count is `$clog2(DEPTH+1)` bits. Each entry holds `addr[XLEN-1:2]` and 4 bytes.
- **Push.** `wr_ready = (count < DEPTH)`, which is registered-state only. A push occurs on an edge where `wr_valid && wr_ready`. A full buffer refuses the push even in a cycle where it pops; there is no pass-through.
- **Drain FSM.**
  - IDLE → WRITE when `!empty && mem_grant`. A down-counter is loaded with `WRITE_CYCLES-1`.
  - In WRITE: `mem_busy=1`, `mem_write_en=1`, `mem_addr={head.addr,2'b00}`, `mem_data_in=head.data`. `mem_grant` is ignored; a write is never aborted except by reset.
  - On the cycle the counter reaches 0: pop the head and return to IDLE. This leaves one idle cycle between consecutive stores.
  - In IDLE: `mem_addr=0`, `mem_data_in=0`, `mem_write_en=0`, `mem_busy=0`.
- **Simultaneous push and pop.** Count stays unchanged; both pointers advance.
- **Push during WRITE.** Allowed; the new entry never disturbs the head being written.
- **Address match.** Combinational compare of `rd_addr[XLEN-1:2]` against every valid entry, including the head currently in WRITE.
- **Youngest wins.** Among multiple matches, the entry closest to the tail supplies the data.
- **Same-cycle store.** A store pushed in the same cycle as a probe is not visible until the next cycle.
- **`empty`.** `empty = (count == 0)`. A store being written is still counted until it pops.
- **Reset.** Asserting `rst_b` low at any time clears pointers and count and forces IDLE. Pending stores are discarded; a store in flight is abandoned. Reset values: `wr_ready=1`, `empty=1`, `mem_write_en=0`, `mem_busy=0`, `mem_addr=0`, `mem_data_in=0`, `fwd_hit=0`, `fwd_data=0`, `rd_stall=0`.

## Timing
- Push latency: an entry is visible to `empty`, the drain FSM and the match logic on the cycle after the accepting edge.
- Drain start: on the first edge with `mem_grant` high while IDLE and non-empty, `mem_write_en` rises for the following cycle.
- Per-store occupancy of the memory port: `WRITE_CYCLES` cycles, then 1 IDLE cycle.
- Throughput with continuous grant: one store per `WRITE_CYCLES+1` cycles.
- Output paths:
  - `wr_ready`, `empty`, `mem_*`, `mem_busy` are driven from registers and FSM state only.
  - `fwd_*` and `rd_stall` are combinational from `rd_addr`.

## Configuration
- `WB_FORWARD_EN` defined:
  - `fwd_hit` = any match.
  - `fwd_data` = youngest match, else 0.
  - `rd_stall` = 0.
- `WB_FORWARD_EN` undefined:
  - `fwd_hit=0` and `fwd_data=0` constant.
  - `rd_stall` = any match; the cache holds the load until the matching store drains.
  - No forwarding mux is synthesized.

## Test plan
- **Reset and single store.** Reset, then push addr 0x100 / data 0xDEADBEEF with `mem_grant=1`. Expect `empty=0` next cycle, then one `mem_write_en` pulse with `mem_addr=0x100` and `mem_data_in[0]=0xEF`, then `empty=1`.
- **Fill, block, wrap.** Hold `mem_grant=0` and push 5 stores with `DEPTH=4`. Expect `wr_ready=0` after the 4th and the 5th held off. Raise grant; writes drain in FIFO order. Push 3 more so the pointers wrap; order is still preserved.
- **Forwarding vs. stall.** Push 0x200=0x11111111, then 0x200=0x22222222, then probe `rd_addr=0x202`. With `WB_FORWARD_EN`: `fwd_hit=1`, `fwd_data=0x22222222`, `rd_stall=0`. Without it: `rd_stall=1` until both stores pop, `fwd_hit=0`.
- **Grant drop and multi-cycle write.** With `WRITE_CYCLES=3`, start a write, then drop `mem_grant` in cycle 2. Expect `mem_write_en` held exactly 3 cycles, then IDLE with no new write until grant returns.
- **Simultaneous push/pop.** With count=2, push on the same edge as the head pops. Expect count to stay 2 and the new data at the tail.
- **Reset mid-write.** Pull `rst_b` low during WRITE. Expect `mem_write_en=0`, `empty=1`, `wr_ready=1` immediately, and no write after release.

Source files
------------

// File: rtl/mem_write_buffer.sv
// Posted-store FIFO between the cache and the memory write port, with address-match
// forwarding (WB_FORWARD_EN defined) or load stall (WB_FORWARD_EN undefined).
module mem_write_buffer #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int WRITE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [XLEN-1:0]      wr_addr,
  input  logic [3:0][7:0]      wr_data,
  input  logic                 mem_grant,
  output logic                 mem_busy,
  output logic [XLEN-1:0]      mem_addr,
  output logic [3:0][7:0]      mem_data_in,
  output logic                 mem_write_en,
  input  logic [XLEN-1:0]      rd_addr,
  output logic                 fwd_hit,
  output logic [3:0][7:0]      fwd_data,
  output logic                 rd_stall,
  output logic                 empty,
  output logic                 dbg_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_e;

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int WCW  = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [WCW-1:0]  WC_LOAD = WCW'(WRITE_CYCLES - 1);

  // Handshake: a store is accepted on an edge where wr_valid && wr_ready; wr_ready
  // depends on the registered count only, so a full buffer never takes a store.
  logic [XLEN-3:0]  addr_q [DEPTH];
  logic [3:0][7:0]  data_q [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [CNTW-1:0]  count_q, count_d;
  logic [WCW-1:0]   wcnt_q;
  state_e           state_q;
  logic [XLEN-1:0]  mem_addr_q;
  logic [3:0][7:0]  mem_data_q;
  logic             mem_we_q;
  logic             push, pop;
  logic             any_match;
  logic [AW-1:0]    idx;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0]};

  assign wr_ready = (count_q < DEPTH_C);
  assign empty    = (count_q == '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = (state_q == ST_WRITE) && (wcnt_q == '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= wr_addr[XLEN-1:2];
      data_q[tail_q] <= wr_data;
    end
  end

  // Drain FSM; mem_* outputs are latched on entry to WRITE and cleared on the pop.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wcnt_q     <= '0;
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;
      case (state_q)
        ST_IDLE: begin
          if ((count_q != '0) && mem_grant) begin
            state_q    <= ST_WRITE;
            wcnt_q     <= WC_LOAD;
            mem_addr_q <= {addr_q[head_q], 2'b00};
            mem_data_q <= data_q[head_q];
            mem_we_q   <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (wcnt_q == '0) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q - WCW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_q;
  assign mem_write_en = mem_we_q;
  assign mem_busy     = (state_q == ST_WRITE);
  assign dbg_state    = state_q;

`ifdef WB_FORWARD_EN
  logic [3:0][7:0] young_data;

  // Walk from head to tail so the youngest matching entry overrides older ones.
  always_comb begin
    any_match  = 1'b0;
    young_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((CNTW'(i) < count_q) && (addr_q[idx] == rd_addr[XLEN-1:2])) begin
        any_match  = 1'b1;
        young_data = data_q[idx];
      end
    end
  end

  assign fwd_hit  = any_match;
  assign fwd_data = young_data;
  assign rd_stall = 1'b0;
`else
  always_comb begin
    any_match = 1'b0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((CNTW'(i) < count_q) && (addr_q[idx] == rd_addr[XLEN-1:2])) begin
        any_match = 1'b1;
      end
    end
  end

  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  assign rd_stall = any_match;
`endif

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: one instance with WRITE_CYCLES=1 for the
// vector table and forwarding, one with WRITE_CYCLES=3 for multi-cycle writes.
module tb_mem_write_buffer;

  logic            clk;
  logic            rst_b;
  logic            wr_valid;
  logic [31:0]     wr_addr;
  logic [3:0][7:0] wr_data;
  logic            mem_grant;
  logic [31:0]     rd_addr;

  logic            d1_ready, d1_busy, d1_we, d1_hit, d1_stall, d1_empty, d1_dbg;
  logic [31:0]     d1_addr;
  logic [3:0][7:0] d1_data, d1_fwd;
  logic            d3_ready, d3_busy, d3_we, d3_hit, d3_stall, d3_empty, d3_dbg;
  logic [31:0]     d3_addr;
  logic [3:0][7:0] d3_data, d3_fwd;

  int n_checks = 0;
  int n_fail   = 0;

  mem_write_buffer #(.XLEN(32), .DEPTH(4), .WRITE_CYCLES(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .wr_valid(wr_valid), .wr_ready(d1_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem_grant(mem_grant),
    .mem_busy(d1_busy), .mem_addr(d1_addr), .mem_data_in(d1_data),
    .mem_write_en(d1_we), .rd_addr(rd_addr), .fwd_hit(d1_hit),
    .fwd_data(d1_fwd), .rd_stall(d1_stall), .empty(d1_empty), .dbg_state(d1_dbg)
  );

  mem_write_buffer #(.XLEN(32), .DEPTH(4), .WRITE_CYCLES(3)) dut3 (
    .clk(clk), .rst_b(rst_b), .wr_valid(wr_valid), .wr_ready(d3_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem_grant(mem_grant),
    .mem_busy(d3_busy), .mem_addr(d3_addr), .mem_data_in(d3_data),
    .mem_write_en(d3_we), .rd_addr(rd_addr), .fwd_hit(d3_hit),
    .fwd_data(d3_fwd), .rd_stall(d3_stall), .empty(d3_empty), .dbg_state(d3_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic        grant;
    logic        e_ready;
    logic        e_empty;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hD000_0000 | a;
  endfunction

  task automatic r(input logic v, input logic [31:0] a, input logic [31:0] d,
                   input logic g, input logic er, input logic ee, input logic ew,
                   input logic [31:0] ea, input logic [31:0] ed);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d; t.grant = g;
    t.e_ready = er; t.e_empty = ee; t.e_we = ew; t.e_addr = ea; t.e_data = ed;
    vecs.push_back(t);
  endtask

  // Scoreboard helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: apply inputs just after the edge, return at the following negedge.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic g, input logic [31:0] ra);
    @(posedge clk);
    #1;
    wr_valid  = v;
    wr_addr   = a;
    wr_data   = d;
    mem_grant = g;
    rd_addr   = ra;
    @(negedge clk);
  endtask

  task automatic chk_fwd(input string name, input logic m, input logic [31:0] d);
`ifdef WB_FORWARD_EN
    chk({name, "_hit"}, d1_hit, m);
    chk({name, "_data"}, d1_fwd, m ? d : 32'h0);
    chk({name, "_stall"}, d1_stall, 1'b0);
`else
    chk({name, "_hit"}, d1_hit, 1'b0);
    chk({name, "_data"}, d1_fwd, 32'h0);
    chk({name, "_stall"}, d1_stall, m);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_b     = 1'b0;
    wr_valid  = 1'b0;
    mem_grant = 1'b0;
    @(negedge clk);
    #2;
    rst_b = 1'b1;
  endtask

  initial begin
    // single store, fill/block/drain, wrap, simultaneous push+pop
    r(0, 0, 0, 0, 1, 1, 0, 0, 0);
    r(1, 32'h100, 32'hDEADBEEF, 1, 1, 1, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 1, 32'h100, 32'hDEADBEEF);
    r(0, 0, 0, 0, 1, 1, 0, 0, 0);
    r(1, 32'h10, dat(32'h10), 0, 1, 1, 0, 0, 0);
    r(1, 32'h14, dat(32'h14), 0, 1, 0, 0, 0, 0);
    r(1, 32'h18, dat(32'h18), 0, 1, 0, 0, 0, 0);
    r(1, 32'h1C, dat(32'h1C), 0, 1, 0, 0, 0, 0);
    r(1, 32'h20, dat(32'h20), 0, 0, 0, 0, 0, 0);
    r(1, 32'h20, dat(32'h20), 1, 0, 0, 0, 0, 0);
    r(1, 32'h20, dat(32'h20), 1, 0, 0, 1, 32'h10, dat(32'h10));
    r(1, 32'h20, dat(32'h20), 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 0, 0, 1, 32'h14, dat(32'h14));
    r(0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 1, 32'h18, dat(32'h18));
    r(0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 1, 32'h1C, dat(32'h1C));
    r(0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 1, 32'h20, dat(32'h20));
    r(0, 0, 0, 0, 1, 1, 0, 0, 0);
    r(1, 32'h30, dat(32'h30), 0, 1, 1, 0, 0, 0);
    r(1, 32'h34, dat(32'h34), 0, 1, 0, 0, 0, 0);
    r(1, 32'h38, dat(32'h38), 0, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 1, 32'h30, dat(32'h30));
    r(0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 1, 32'h34, dat(32'h34));
    r(0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 1, 32'h38, dat(32'h38));
    r(0, 0, 0, 0, 1, 1, 0, 0, 0);
    r(1, 32'h40, dat(32'h40), 0, 1, 1, 0, 0, 0);
    r(1, 32'h44, dat(32'h44), 1, 1, 0, 0, 0, 0);
    r(1, 32'h48, dat(32'h48), 0, 1, 0, 1, 32'h40, dat(32'h40));
    r(1, 32'h4C, dat(32'h4C), 0, 1, 0, 0, 0, 0);
    r(1, 32'h50, dat(32'h50), 0, 1, 0, 0, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0, 0, 0);
    r(0, 0, 0, 1, 0, 0, 0, 0, 0);
    r(0, 0, 0, 1, 0, 0, 1, 32'h44, dat(32'h44));
    r(0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 1, 32'h48, dat(32'h48));
    r(0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 1, 32'h4C, dat(32'h4C));
    r(0, 0, 0, 1, 1, 0, 0, 0, 0);
    r(0, 0, 0, 1, 1, 0, 1, 32'h50, dat(32'h50));
    r(0, 0, 0, 0, 1, 1, 0, 0, 0);

    rst_b     = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    mem_grant = 1'b0;
    rd_addr   = 32'hFFF0;
    @(negedge clk);
    chk("rst_ready", d1_ready, 1'b1);
    chk("rst_empty", d1_empty, 1'b1);
    chk("rst_we", d1_we, 1'b0);
    chk("rst_busy", d1_busy, 1'b0);
    chk("rst_addr", d1_addr, 32'h0);
    chk("rst_data", d1_data, 32'h0);
    chk("rst_hit", d1_hit, 1'b0);
    chk("rst_fwd", d1_fwd, 32'h0);
    chk("rst_stall", d1_stall, 1'b0);
    chk("rst3_we", d3_we, 1'b0);
    chk("rst3_empty", d3_empty, 1'b0 | 1'b1);
    #2;
    rst_b = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].grant, 32'hFFF0);
      chk($sformatf("v%0d_ready", i), d1_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_empty", i), d1_empty, vecs[i].e_empty);
      chk($sformatf("v%0d_we", i), d1_we, vecs[i].e_we);
      chk($sformatf("v%0d_busy", i), d1_busy, vecs[i].e_we);
      chk($sformatf("v%0d_addr", i), d1_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_data", i), d1_data, vecs[i].e_data);
      chk($sformatf("v%0d_byte0", i), d1_data[0], vecs[i].e_data[7:0]);
      chk($sformatf("v%0d_hit", i), d1_hit, 1'b0);
      chk($sformatf("v%0d_stall", i), d1_stall, 1'b0);
    end

    // forwarding vs stall, youngest wins, same-cycle store invisible
    do_reset();
    drive(1, 32'h200, 32'h11111111, 0, 32'h200);
    chk_fwd("fw_same", 1'b0, 32'h0);
    drive(1, 32'h200, 32'h22222222, 0, 32'h202);
    chk_fwd("fw_one", 1'b1, 32'h11111111);
    drive(0, 0, 0, 0, 32'h202);
    chk_fwd("fw_young", 1'b1, 32'h22222222);
    drive(0, 0, 0, 1, 32'h202);
    chk_fwd("fw_idle2", 1'b1, 32'h22222222);
    drive(0, 0, 0, 1, 32'h202);
    chk("fw_we1", d1_we, 1'b1);
    chk_fwd("fw_wr1", 1'b1, 32'h22222222);
    drive(0, 0, 0, 1, 32'h202);
    chk_fwd("fw_idle1", 1'b1, 32'h22222222);
    drive(0, 0, 0, 1, 32'h202);
    chk("fw_we2", d1_we, 1'b1);
    chk_fwd("fw_wr2", 1'b1, 32'h22222222);
    drive(0, 0, 0, 0, 32'h202);
    chk_fwd("fw_done", 1'b0, 32'h0);
    chk("fw_empty", d1_empty, 1'b1);

    // multi-cycle write with grant dropped mid-write
    do_reset();
    drive(1, 32'h300, dat(32'h300), 0, 32'hFFF0);
    drive(1, 32'h304, dat(32'h304), 0, 32'hFFF0);
    drive(0, 0, 0, 1, 32'hFFF0);
    chk("gd_pre_we", d3_we, 1'b0);
    drive(0, 0, 0, 1, 32'hFFF0);
    chk("gd_c1_we", d3_we, 1'b1);
    chk("gd_c1_addr", d3_addr, 32'h300);
    drive(0, 0, 0, 0, 32'hFFF0);
    chk("gd_c2_we", d3_we, 1'b1);
    chk("gd_c2_busy", d3_busy, 1'b1);
    drive(0, 0, 0, 0, 32'hFFF0);
    chk("gd_c3_we", d3_we, 1'b1);
    chk("gd_c3_data", d3_data, dat(32'h300));
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 32'hFFF0);
      chk($sformatf("gd_idle%0d_we", k), d3_we, 1'b0);
      chk($sformatf("gd_idle%0d_empty", k), d3_empty, 1'b0);
    end
    drive(0, 0, 0, 1, 32'hFFF0);
    chk("gd_regrant_we", d3_we, 1'b0);
    drive(0, 0, 0, 1, 32'hFFF0);
    chk("gd_second_we", d3_we, 1'b1);
    chk("gd_second_addr", d3_addr, 32'h304);

    // reset in the middle of a write
    #2;
    rst_b = 1'b0;
    #1;
    chk("mr_we", d3_we, 1'b0);
    chk("mr_busy", d3_busy, 1'b0);
    chk("mr_empty", d3_empty, 1'b1);
    chk("mr_ready", d3_ready, 1'b1);
    chk("mr_addr", d3_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, 32'hFFF0);
      chk($sformatf("mr_post%0d_we", k), d3_we, 1'b0);
      chk($sformatf("mr_post%0d_we1", k), d1_we, 1'b0);
      chk($sformatf("mr_post%0d_empty", k), d3_empty, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
